// File: rtl/uart_pkg.sv
// Shared constants for the wishbone FIFO UART: register map, status and
// interrupt-enable bit positions, parity mode codes, TX/RX state encodings.
package uart_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_IER  = 2'd2;
    localparam logic [1:0] ADDR_DIV  = 2'd3;

    localparam int ST_RX_NEMPTY = 0;
    localparam int ST_RX_FULL   = 1;
    localparam int ST_TX_EMPTY  = 2;
    localparam int ST_TX_FULL   = 3;
    localparam int ST_OVERRUN   = 4;
    localparam int ST_FRAME     = 5;
    localparam int ST_PARITY    = 6;
    localparam int ST_TX_BUSY   = 7;

    localparam int IE_RX  = 0;
    localparam int IE_TX  = 1;
    localparam int IE_ERR = 2;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
    } rx_state_t;

    // Parity bit that makes the 9-bit word odd/even weight.
    function automatic logic par_bit(input logic [7:0] d, input int mode);
        return (mode == PAR_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_fifo_wb_if.sv
// Wishbone-style register bus between a master (CPU/test FSM) and the UART.
// Signals: cyc, we, 2-bit addr, 8-bit write data, 8-bit read data, interrupt.
interface uart_fifo_wb_if;

    logic       wb_cyc_i;
    logic       wb_we_i;
    logic [1:0] wb_addr_i;
    logic [7:0] wb_datw_i;
    logic [7:0] wb_datr_o;
    logic       wb_int_o;

    modport master (
        output wb_cyc_i, wb_we_i, wb_addr_i, wb_datw_i,
        input  wb_datr_o, wb_int_o
    );

    modport slave (
        input  wb_cyc_i, wb_we_i, wb_addr_i, wb_datw_i,
        output wb_datr_o, wb_int_o
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO, depth 2**AW, combinational read of the head entry.
// Ports: clk, rst (sync high), push/wdata, pop/rdata, empty, full, count.
module uart_sync_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    logic [7:0]  mem [2**AW];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_push;
    logic        do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO still
    // accepts a simultaneous push; an empty one cannot pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign rdata = mem[rptr[AW-1:0]];
    assign count = wptr - rptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_fifo_wb.sv
// 8-bit UART with run-time baud divider, RX/TX FIFOs, optional parity,
// sticky error flags and masked interrupt behind a 4-register bus.
// Ports: wb_clk_i, rst_i (sync high), wb (bus slave), uart_rx, uart_tx,
// uart_cts_i, uart_rts_o. Optional macro UART_HW_FLOW_EN adds CTS/RTS.
module uart_fifo_wb
    import uart_pkg::*;
#(
    parameter int FIFO_AW = 4,
    parameter int DIV_RST = 26,
    parameter int PARITY  = 0
) (
    input  logic           wb_clk_i,
    input  logic           rst_i,
    uart_fifo_wb_if.slave  wb,
    input  logic           uart_rx,
    output logic           uart_tx,
    input  logic           uart_cts_i,
    output logic           uart_rts_o
);

    localparam int   DEPTH   = 2**FIFO_AW;
    localparam logic HAS_PAR = (PARITY != PAR_NONE);

    logic         cyc_q;
    logic         strobe;
    logic         wr;
    logic         rd;
    logic         stat_rd;
    logic         div_wr;
    logic [7:0]   datr_q;
    logic [7:0]   rd_data;
    logic [7:0]   status;
    logic         irq_q;
    logic [2:0]   ier;
    logic [2:0]   irq_cond;
    logic [7:0]   div;
    logic         overrun;
    logic         frame_err;
    logic         parity_err;
    logic         ovr_set;
    logic         fe_set;
    logic         pe_set;
    logic         cts_ok;

    logic [7:0]   tick_cnt;
    logic         tick;

    logic         tx_push;
    logic         tx_pop;
    logic         tx_empty;
    logic         tx_full;
    logic [7:0]   tx_rdata;
    logic [FIFO_AW:0] tx_count;

    logic         rx_push;
    logic         rx_pop;
    logic         rx_empty;
    logic         rx_full;
    logic [7:0]   rx_rdata;
    logic [FIFO_AW:0] rx_count;

    tx_state_t    tx_state;
    tx_state_t    tx_state_nxt;
    logic [3:0]   tx_tcnt;
    logic [3:0]   tx_tcnt_nxt;
    logic [2:0]   tx_bit;
    logic [2:0]   tx_bit_nxt;
    logic [7:0]   tx_sh;
    logic [7:0]   tx_sh_nxt;
    logic         tx_par;
    logic         tx_par_nxt;
    logic         tx_line_nxt;
    logic         tx_bit_end;

    rx_state_t    rx_state;
    rx_state_t    rx_state_nxt;
    logic [3:0]   rx_tcnt;
    logic [3:0]   rx_tcnt_nxt;
    logic [2:0]   rx_bit;
    logic [2:0]   rx_bit_nxt;
    logic [7:0]   rx_sh;
    logic [7:0]   rx_sh_nxt;
    logic         rx_s1;
    logic         rx_sync;
    logic         rx_prev;
    logic         rx_mid;

    // ---------------- bus decode ----------------
    assign strobe  = wb.wb_cyc_i & ~cyc_q;
    assign wr      = strobe & wb.wb_we_i;
    assign rd      = strobe & ~wb.wb_we_i;
    assign tx_push = wr && (wb.wb_addr_i == ADDR_DATA);
    assign rx_pop  = rd && (wb.wb_addr_i == ADDR_DATA);
    assign stat_rd = rd && (wb.wb_addr_i == ADDR_STAT);
    assign div_wr  = wr && (wb.wb_addr_i == ADDR_DIV);

    assign wb.wb_datr_o = datr_q;
    assign wb.wb_int_o  = irq_q;

    always_comb begin
        status               = '0;
        status[ST_RX_NEMPTY] = ~rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_TX_FULL]   = tx_full;
        status[ST_OVERRUN]   = overrun;
        status[ST_FRAME]     = frame_err;
        status[ST_PARITY]    = parity_err;
        status[ST_TX_BUSY]   = (tx_state != TX_IDLE);
    end

    always_comb begin
        rd_data = '0;
        unique case (wb.wb_addr_i)
            ADDR_DATA: rd_data = rx_empty ? 8'h00 : rx_rdata;
            ADDR_STAT: rd_data = status;
            ADDR_IER:  rd_data = {5'b0, ier};
            ADDR_DIV:  rd_data = div;
            default:   rd_data = '0;
        endcase
    end

    assign irq_cond[IE_RX]  = ~rx_empty;
    assign irq_cond[IE_TX]  = tx_empty;
    assign irq_cond[IE_ERR] = overrun | frame_err | parity_err;

    // A full RX FIFO being read in the same cycle still takes the byte.
    assign ovr_set = rx_push & rx_full & ~rx_pop;

    always_ff @(posedge wb_clk_i) begin
        if (rst_i) begin
            cyc_q      <= 1'b0;
            datr_q     <= '0;
            irq_q      <= 1'b0;
            ier        <= '0;
            div        <= 8'(DIV_RST);
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            cyc_q <= wb.wb_cyc_i;
            if (rd) datr_q <= rd_data;
            if (wr && (wb.wb_addr_i == ADDR_IER)) ier <= wb.wb_datw_i[2:0];
            if (div_wr) div <= wb.wb_datw_i;
            // New event beats the clearing read.
            overrun    <= (overrun & ~stat_rd) | ovr_set;
            frame_err  <= (frame_err & ~stat_rd) | fe_set;
            parity_err <= (parity_err & ~stat_rd) | pe_set;
            irq_q      <= |(ier & irq_cond);
        end
    end

    // ---------------- 16x tick ----------------
    assign tick = (tick_cnt == div);

    always_ff @(posedge wb_clk_i) begin
        if (rst_i) tick_cnt <= '0;
        else if (div_wr || tick) tick_cnt <= '0;
        else tick_cnt <= tick_cnt + 8'd1;
    end

    // ---------------- FIFOs ----------------
    uart_sync_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk   (wb_clk_i),
        .rst   (rst_i),
        .push  (tx_push),
        .wdata (wb.wb_datw_i),
        .pop   (tx_pop),
        .rdata (tx_rdata),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    uart_sync_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk   (wb_clk_i),
        .rst   (rst_i),
        .push  (rx_push),
        .wdata (rx_sh),
        .pop   (rx_pop),
        .rdata (rx_rdata),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    // ---------------- flow control ----------------
`ifdef UART_HW_FLOW_EN
    logic cts_s1;
    logic cts_s2;

    always_ff @(posedge wb_clk_i) begin
        if (rst_i) begin
            cts_s1 <= 1'b0;
            cts_s2 <= 1'b0;
        end else begin
            cts_s1 <= uart_cts_i;
            cts_s2 <= cts_s1;
        end
    end

    assign cts_ok     = cts_s2;
    assign uart_rts_o = (rx_count < (FIFO_AW+1)'(DEPTH - 2));
`else
    logic unused_flow;
    assign unused_flow = uart_cts_i ^ (^rx_count);
    assign cts_ok      = 1'b1;
    assign uart_rts_o  = 1'b1;
`endif

    logic unused_tx_count;
    assign unused_tx_count = ^tx_count;

    // ---------------- TX FSM ----------------
    assign tx_bit_end = tick && (tx_tcnt == 4'd15);

    always_ff @(posedge wb_clk_i) begin
        if (rst_i) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_tcnt  <= tx_tcnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_sh    <= tx_sh_nxt;
            tx_par   <= tx_par_nxt;
            uart_tx  <= tx_line_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_tcnt_nxt  = tx_tcnt;
        tx_bit_nxt   = tx_bit;
        tx_sh_nxt    = tx_sh;
        tx_par_nxt   = tx_par;
        tx_pop       = 1'b0;
        if (tick && (tx_state != TX_IDLE)) tx_tcnt_nxt = tx_tcnt + 4'd1;
        unique case (tx_state)
            TX_IDLE: begin
                if (tick && !tx_empty && cts_ok) begin
                    tx_state_nxt = TX_START;
                    tx_tcnt_nxt  = '0;
                    tx_sh_nxt    = tx_rdata;
                    tx_par_nxt   = par_bit(tx_rdata, PARITY);
                    tx_pop       = 1'b1;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_nxt = TX_DATA;
                    tx_bit_nxt   = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_sh_nxt = {1'b0, tx_sh[7:1]};
                    if (tx_bit == 3'd7)
                        tx_state_nxt = HAS_PAR ? TX_PAR : TX_STOP;
                    else
                        tx_bit_nxt = tx_bit + 3'd1;
                end
            end
            TX_PAR: if (tx_bit_end) tx_state_nxt = TX_STOP;
            TX_STOP: if (tx_bit_end) tx_state_nxt = TX_IDLE;
            default: tx_state_nxt = TX_IDLE;
        endcase

        // Line level follows the next state so the pin is a clean flop.
        tx_line_nxt = 1'b1;
        unique case (tx_state_nxt)
            TX_START: tx_line_nxt = 1'b0;
            TX_DATA:  tx_line_nxt = tx_sh_nxt[0];
            TX_PAR:   tx_line_nxt = tx_par_nxt;
            default:  tx_line_nxt = 1'b1;
        endcase
    end

    // ---------------- RX FSM ----------------
    assign rx_mid = tick && (rx_tcnt == 4'd15);

    always_ff @(posedge wb_clk_i) begin
        if (rst_i) begin
            rx_s1    <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_s1    <= uart_rx;
            rx_sync  <= rx_s1;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_nxt;
            rx_tcnt  <= rx_tcnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_sh    <= rx_sh_nxt;
        end
    end

    // Start bit is checked 8 ticks after the edge; every later sample
    // lands 16 ticks after the previous one, i.e. mid-bit.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_tcnt_nxt  = rx_tcnt;
        rx_bit_nxt   = rx_bit;
        rx_sh_nxt    = rx_sh;
        rx_push      = 1'b0;
        fe_set       = 1'b0;
        pe_set       = 1'b0;
        if (tick && (rx_state != RX_IDLE)) rx_tcnt_nxt = rx_tcnt + 4'd1;
        unique case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_nxt = RX_START;
                    rx_tcnt_nxt  = '0;
                end
            end
            RX_START: begin
                if (tick && (rx_tcnt == 4'd7)) begin
                    rx_tcnt_nxt  = '0;
                    rx_bit_nxt   = '0;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_mid) begin
                    rx_sh_nxt = {rx_sync, rx_sh[7:1]};
                    if (rx_bit == 3'd7)
                        rx_state_nxt = HAS_PAR ? RX_PAR : RX_STOP;
                    else
                        rx_bit_nxt = rx_bit + 3'd1;
                end
            end
            RX_PAR: begin
                if (rx_mid) begin
                    pe_set       = (rx_sync != par_bit(rx_sh, PARITY));
                    rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_mid) begin
                    rx_push      = rx_sync;
                    fe_set       = ~rx_sync;
                    rx_state_nxt = RX_IDLE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_wb.sv
// Self-checking bench for uart_fifo_wb (PARITY=even, FIFO_AW=4): serial
// frames are built/decoded by the bench and compared to a queue model.
module tb_uart_fifo_wb;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic drv_rx = 1'b1;
    logic loop = 1'b0;
    logic cts = 1'b1;
    logic rx_line;
    logic uart_tx;
    logic uart_rts;

    uart_fifo_wb_if bus();

    assign rx_line = loop ? uart_tx : drv_rx;

    uart_fifo_wb #(
        .FIFO_AW (4),
        .DIV_RST (26),
        .PARITY  (2)
    ) dut (
        .wb_clk_i   (clk),
        .rst_i      (rst),
        .wb         (bus),
        .uart_rx    (rx_line),
        .uart_tx    (uart_tx),
        .uart_cts_i (cts),
        .uart_rts_o (uart_rts)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    byte unsigned rx_q[$];
    bit m_ovr = 0;
    bit m_fe  = 0;
    bit m_pe  = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic even_par(input logic [7:0] b);
        return logic'($countones(b) % 2);
    endfunction

    function automatic logic [7:0] m_status();
        logic [7:0] s;
        s = '0;
        s[0] = (rx_q.size() != 0);
        s[1] = (rx_q.size() == DEPTH);
        s[2] = 1'b1;
        s[4] = m_ovr;
        s[5] = m_fe;
        s[6] = m_pe;
        return s;
    endfunction

    function automatic logic m_rts();
`ifdef UART_HW_FLOW_EN
        return (rx_q.size() >= DEPTH - 2) ? 1'b0 : 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    task automatic m_push(input logic [7:0] b);
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else m_ovr = 1;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.wb_cyc_i  = 1'b1;
        bus.wb_we_i   = 1'b1;
        bus.wb_addr_i = a;
        bus.wb_datw_i = d;
        @(negedge clk);
        bus.wb_cyc_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.wb_cyc_i  = 1'b1;
        bus.wb_we_i   = 1'b0;
        bus.wb_addr_i = a;
        @(negedge clk);
        d = bus.wb_datr_o;
        bus.wb_cyc_i = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [7:0] s;
        wb_read(ADDR_STAT, s);
        check(tag, s, m_status());
        m_ovr = 0;
        m_fe  = 0;
        m_pe  = 0;
    endtask

    task automatic check_pop(input string tag);
        logic [7:0] d;
        logic [7:0] e;
        e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        wb_read(ADDR_DATA, d);
        check(tag, d, e);
    endtask

    // One frame at 16 clocks per bit (DIV=0) followed by one idle bit.
    task automatic send_serial(input logic [7:0] b, input logic stop,
                               input logic good_par);
        logic [10:0] f;
        logic p;
        p = good_par ? even_par(b) : ~even_par(b);
        f = {stop, p, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drv_rx = f[i];
            repeat (15) @(negedge clk);
        end
        @(negedge clk);
        drv_rx = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    // Waits for a start bit, records the line every clock up to mid-stop,
    // then decodes by sampling each bit period at its centre.
    task automatic capture_tx(input int bc, output logic [7:0] b,
                              output logic p, output logic st,
                              output int sw);
        logic smp [0:2047];
        int t;
        int n;
        t = 0;
        @(negedge clk);
        while (uart_tx !== 1'b0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("tx_start_seen", {31'b0, uart_tx}, 32'd0);
        n = 10 * bc + bc / 2 + 1;
        smp[0] = uart_tx;
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            smp[k] = uart_tx;
        end
        for (int i = 0; i < 8; i++) b[i] = smp[(i + 1) * bc + bc / 2];
        p  = smp[9 * bc + bc / 2];
        st = smp[10 * bc + bc / 2];
        sw = 0;
        while (sw < n && smp[sw] == 1'b0) sw++;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [7:0] rd;
    logic [7:0] b;
    logic [7:0] cb;
    logic       cp;
    logic       cs;
    int         sw;
    int         dv;
    int         low;
    logic [7:0] fb [3];

    initial begin
        bus.wb_cyc_i  = 1'b0;
        bus.wb_we_i   = 1'b0;
        bus.wb_addr_i = '0;
        bus.wb_datw_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_tx", {31'b0, uart_tx}, 32'd1);
        check("rst_rts", {31'b0, uart_rts}, 32'd1);
        check("rst_int", {31'b0, bus.wb_int_o}, 32'd0);
        check("rst_datr", {24'b0, bus.wb_datr_o}, 32'd0);
        check_status("rst_status");
        wb_read(ADDR_DIV, rd);
        check("rst_div", rd, 32'd26);
        wb_read(ADDR_IER, rd);
        check("rst_ier", rd, 32'd0);

        // 0x55 at DIV=0: 16 clocks per bit
        wb_write(ADDR_DIV, 8'd0);
        wb_write(ADDR_DATA, 8'h55);
        capture_tx(16, cb, cp, cs, sw);
        check("tx55_start_width", sw, 32'd16);
        check("tx55_data", cb, 32'h55);
        check("tx55_parity", {31'b0, cp}, {31'b0, even_par(8'h55)});
        check("tx55_stop", {31'b0, cs}, 32'd1);
        repeat (20) @(negedge clk);
        check_status("tx55_done_status");

        // Random divider, random byte
        for (int i = 0; i < 2; i++) begin
            dv = $urandom_range(1, 3);
            b  = 8'($urandom);
            wb_write(ADDR_DIV, 8'(dv));
            wb_write(ADDR_DATA, b);
            capture_tx(16 * (dv + 1), cb, cp, cs, sw);
            check("txdiv_data", cb, b);
            check("txdiv_parity", {31'b0, cp}, {31'b0, even_par(b)});
            check("txdiv_stop", {31'b0, cs}, 32'd1);
            repeat (16 * (dv + 1)) @(negedge clk);
        end
        wb_write(ADDR_DIV, 8'd0);
        wb_read(ADDR_DIV, rd);
        check("div_readback", rd, 32'd0);

        // Loopback with even parity
        loop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'hA5 : 8'($urandom);
            wb_write(ADDR_DATA, b);
            m_push(b);
            repeat (250) @(negedge clk);
            check_status("loop_status");
            check_pop("loop_data");
        end
        loop = 1'b0;

        // 17 bytes into a 16-deep RX FIFO
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            send_serial(b, 1'b1, 1'b1);
            m_push(b);
        end
        wb_write(ADDR_IER, 8'h01);
        repeat (3) @(negedge clk);
        check("ovr_int_rx", {31'b0, bus.wb_int_o}, 32'd1);
        check("ovr_rts", {31'b0, uart_rts}, {31'b0, m_rts()});
        check_status("ovr_status");
        check_status("ovr_status_cleared");
        for (int i = 0; i < DEPTH; i++) check_pop("ovr_data");
        check_pop("empty_read_zero");
        repeat (3) @(negedge clk);
        check("ovr_int_off", {31'b0, bus.wb_int_o}, 32'd0);
        check("rts_after_drain", {31'b0, uart_rts}, 32'd1);

        // Frame error with error interrupt
        wb_write(ADDR_IER, 8'h04);
        send_serial(8'($urandom), 1'b0, 1'b1);
        m_fe = 1;
        repeat (3) @(negedge clk);
        check("fe_int_on", {31'b0, bus.wb_int_o}, 32'd1);
        check_status("fe_status");
        repeat (3) @(negedge clk);
        check("fe_int_off", {31'b0, bus.wb_int_o}, 32'd0);
        check_status("fe_status_cleared");
        wb_write(ADDR_IER, 8'h00);

        // Parity error: byte still stored
        b = 8'($urandom);
        send_serial(b, 1'b1, 1'b0);
        m_push(b);
        m_pe = 1;
        check_status("pe_status");
        check_pop("pe_data");

        // One-clock glitch is a false start
        @(negedge clk);
        drv_rx = 1'b0;
        @(negedge clk);
        drv_rx = 1'b1;
        repeat (60) @(negedge clk);
        check_status("glitch_status");
        b = 8'($urandom);
        send_serial(b, 1'b1, 1'b1);
        m_push(b);
        check_pop("after_glitch_data");

`ifdef UART_HW_FLOW_EN
        cts = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fb[i] = 8'($urandom);
            wb_write(ADDR_DATA, fb[i]);
        end
        low = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) low++;
        end
        check("cts_tx_held", low, 32'd0);
        wb_read(ADDR_STAT, rd);
        check("cts_status", rd, 32'h00);
        cts = 1'b1;
        for (int i = 0; i < 3; i++) begin
            capture_tx(16, cb, cp, cs, sw);
            check("cts_frame_data", cb, fb[i]);
            check("cts_frame_stop", {31'b0, cs}, 32'd1);
        end
`else
        cts = 1'b0;
        fb[0] = 8'($urandom);
        wb_write(ADDR_DATA, fb[0]);
        capture_tx(16, cb, cp, cs, sw);
        check("nocts_data", cb, fb[0]);
        check("nocts_rts", {31'b0, uart_rts}, 32'd1);
        cts = 1'b1;
`endif
        repeat (20) @(negedge clk);
        check_status("final_status");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
